// File: rtl/id_stage_pipelined.sv
// Pipelined RV32I decode stage.
// Decodes the IF/ID instruction, reads operands from the external register
// file with a WB->ID bypass, builds immediates and ALU/branch/memory controls,
// and registers everything into ID/EX. It also handles the load-use stall,
// the flush from EX, and a sticky stop on an illegal opcode.
module id_stage_pipelined #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int ALUSEL_W   = 4,
    parameter int LOAD_STALL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [XLEN-1:0]     if_pc,
    input  logic [31:0]         if_instr,
    output logic                id_ready,
    input  logic                flush,
    output logic [RA_W-1:0]     rf_ra0,
    output logic [RA_W-1:0]     rf_ra1,
    input  logic [XLEN-1:0]     rf_rd0,
    input  logic [XLEN-1:0]     rf_rd1,
    input  logic                wb_we,
    input  logic [RA_W-1:0]     wb_wa,
    input  logic [XLEN-1:0]     wb_wd,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_src1,
    output logic [XLEN-1:0]     ex_src2,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [ALUSEL_W-1:0] ex_alu_sel,
    output logic [2:0]          ex_br_type,
    output logic                ex_branch,
    output logic                ex_jal,
    output logic                ex_jalr,
    output logic [RA_W-1:0]     ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [1:0]          ex_wb_sel,
    output logic                stop
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALUSEL_W-1:0] ALU_ADD  = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] ALU_SUB  = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] ALU_AND  = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] ALU_OR   = ALUSEL_W'(3);
    localparam logic [ALUSEL_W-1:0] ALU_XOR  = ALUSEL_W'(4);
    localparam logic [ALUSEL_W-1:0] ALU_SLT  = ALUSEL_W'(5);
    localparam logic [ALUSEL_W-1:0] ALU_SLTU = ALUSEL_W'(6);
    localparam logic [ALUSEL_W-1:0] ALU_SLL  = ALUSEL_W'(7);
    localparam logic [ALUSEL_W-1:0] ALU_SRL  = ALUSEL_W'(8);
    localparam logic [ALUSEL_W-1:0] ALU_SRA  = ALUSEL_W'(9);

    // funct3 -> ALU select; alt selects sub / sra (instr[30])
    function automatic logic [ALUSEL_W-1:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    // Operand read: x0 is hard zero, a same-cycle WB write wins over the RF
    function automatic logic [XLEN-1:0] opnd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf,
                                             input logic we, input logic [RA_W-1:0] wa,
                                             input logic [XLEN-1:0] wd);
        if (rs == '0)
            opnd = '0;
        else if (we && (wa == rs))
            opnd = wd;
        else
            opnd = rf;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rs1    = RA_W'(if_instr[19:15]);
    assign rs2    = RA_W'(if_instr[24:20]);
    assign rd     = RA_W'(if_instr[11:7]);
    assign rf_ra0 = rs1;
    assign rf_ra1 = rs2;

    assign rs1_val = opnd(rs1, rf_rd0, wb_we, wb_wa, wb_wd);
    assign rs2_val = opnd(rs2, rf_rd1, wb_we, wb_wa, wb_wd);

    logic                dec_legal, dec_rs1_use, dec_rs2_use, dec_reg_wr;
    logic                dec_mem_rd, dec_mem_wr, dec_branch, dec_jal, dec_jalr;
    logic                dec_src1_pc, dec_src1_zero, dec_src2_imm;
    logic [1:0]          dec_wb_sel;
    logic [ALUSEL_W-1:0] dec_alu_sel;
    logic [31:0]         dec_imm32;
    logic [XLEN-1:0]     dec_imm;

    // Instruction decode: controls and raw 32-bit immediate per opcode format
    always_comb begin
        dec_legal     = 1'b1;
        dec_rs1_use   = 1'b0;
        dec_rs2_use   = 1'b0;
        dec_reg_wr    = 1'b0;
        dec_mem_rd    = 1'b0;
        dec_mem_wr    = 1'b0;
        dec_branch    = 1'b0;
        dec_jal       = 1'b0;
        dec_jalr      = 1'b0;
        dec_src1_pc   = 1'b0;
        dec_src1_zero = 1'b0;
        dec_src2_imm  = 1'b1;
        dec_wb_sel    = 2'd0;
        dec_alu_sel   = ALU_ADD;
        dec_imm32     = '0;
        case (opcode)
            OPC_OP: begin
                dec_rs1_use  = 1'b1;
                dec_rs2_use  = 1'b1;
                dec_reg_wr   = 1'b1;
                dec_src2_imm = 1'b0;
                dec_alu_sel  = alu_dec(funct3, if_instr[30]);
            end
            OPC_OPIMM: begin
                dec_rs1_use = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
                dec_alu_sel = alu_dec(funct3, (funct3 == 3'b101) && if_instr[30]);
            end
            OPC_LOAD: begin
                dec_rs1_use = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_mem_rd  = 1'b1;
                dec_wb_sel  = 2'd1;
                dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_STORE: begin
                dec_rs1_use = 1'b1;
                dec_rs2_use = 1'b1;
                dec_mem_wr  = 1'b1;
                dec_imm32   = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec_rs1_use  = 1'b1;
                dec_rs2_use  = 1'b1;
                dec_branch   = 1'b1;
                dec_src2_imm = 1'b0;
                dec_alu_sel  = ALU_SUB;
                dec_imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                dec_reg_wr  = 1'b1;
                dec_jal     = 1'b1;
                dec_src1_pc = 1'b1;
                dec_wb_sel  = 2'd2;
                dec_imm32   = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                               if_instr[20], if_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec_rs1_use = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_jalr    = 1'b1;
                dec_wb_sel  = 2'd2;
                dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OPC_LUI: begin
                dec_reg_wr    = 1'b1;
                dec_src1_zero = 1'b1;
                dec_imm32     = {if_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_reg_wr  = 1'b1;
                dec_src1_pc = 1'b1;
                dec_imm32   = {if_instr[31:12], 12'b0};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_imm = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};

    logic                ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]     ex_pc_q, ex_pc_d, ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
    logic [XLEN-1:0]     ex_rs2_data_q, ex_rs2_data_d, ex_imm_q, ex_imm_d;
    logic [ALUSEL_W-1:0] ex_alu_sel_q, ex_alu_sel_d;
    logic [2:0]          ex_br_type_q, ex_br_type_d;
    logic                ex_branch_q, ex_branch_d, ex_jal_q, ex_jal_d, ex_jalr_q, ex_jalr_d;
    logic [RA_W-1:0]     ex_rd_q, ex_rd_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q, ex_mem_read_d, ex_mem_write_q, ex_mem_write_d;
    logic [1:0]          ex_wb_sel_q, ex_wb_sel_d;
    logic                stop_q, stop_d;
    logic                load_use, issue;

    // Load-use hazard: the load in EX writes a register this instruction reads
    always_comb begin
        load_use = 1'b0;
        if ((LOAD_STALL != 0) && if_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0))
            load_use = (dec_rs1_use && (rs1 == ex_rd_q)) || (dec_rs2_use && (rs2 == ex_rd_q));
    end

    assign id_ready = flush || (!stop_q && !load_use);

    // Next ID/EX contents: flush > stop > stall > issue; anything else is a zero bubble
    always_comb begin
        issue  = 1'b0;
        stop_d = stop_q;
        if (!flush && !stop_q && !load_use && if_valid && (if_instr != 32'h0)) begin
            if (dec_legal)
                issue = 1'b1;
            else
                stop_d = 1'b1;
        end
        ex_valid_d     = issue;
        ex_pc_d        = issue ? if_pc : '0;
        ex_src1_d      = '0;
        if (issue)
            ex_src1_d  = dec_src1_zero ? '0 : (dec_src1_pc ? if_pc : rs1_val);
        ex_src2_d      = issue ? (dec_src2_imm ? dec_imm : rs2_val) : '0;
        ex_rs2_data_d  = issue ? rs2_val : '0;
        ex_imm_d       = issue ? dec_imm : '0;
        ex_alu_sel_d   = issue ? dec_alu_sel : ALU_ADD;
        ex_br_type_d   = (issue && dec_branch) ? funct3 : 3'b0;
        ex_branch_d    = issue && dec_branch;
        ex_jal_d       = issue && dec_jal;
        ex_jalr_d      = issue && dec_jalr;
        ex_rd_d        = issue ? rd : '0;
        ex_reg_write_d = issue && dec_reg_wr && (rd != '0);
        ex_mem_read_d  = issue && dec_mem_rd;
        ex_mem_write_d = issue && dec_mem_wr;
        ex_wb_sel_d    = issue ? dec_wb_sel : 2'd0;
    end

    // ID/EX pipeline register and sticky stop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_src1_q      <= '0;
            ex_src2_q      <= '0;
            ex_rs2_data_q  <= '0;
            ex_imm_q       <= '0;
            ex_alu_sel_q   <= '0;
            ex_br_type_q   <= '0;
            ex_branch_q    <= 1'b0;
            ex_jal_q       <= 1'b0;
            ex_jalr_q      <= 1'b0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_wb_sel_q    <= '0;
            stop_q         <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_src1_q      <= ex_src1_d;
            ex_src2_q      <= ex_src2_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_alu_sel_q   <= ex_alu_sel_d;
            ex_br_type_q   <= ex_br_type_d;
            ex_branch_q    <= ex_branch_d;
            ex_jal_q       <= ex_jal_d;
            ex_jalr_q      <= ex_jalr_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_wb_sel_q    <= ex_wb_sel_d;
            stop_q         <= stop_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_src1      = ex_src1_q;
    assign ex_src2      = ex_src2_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_alu_sel   = ex_alu_sel_q;
    assign ex_br_type   = ex_br_type_q;
    assign ex_branch    = ex_branch_q;
    assign ex_jal       = ex_jal_q;
    assign ex_jalr      = ex_jalr_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_wb_sel    = ex_wb_sel_q;
    assign stop         = stop_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed-vector bench for id_stage_pipelined with hand-computed expectations.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        flush;
    logic [4:0]  rf_ra0, rf_ra1;
    logic [31:0] rf_rd0, rf_rd1;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_src1, ex_src2, ex_rs2_data, ex_imm;
    logic [3:0]  ex_alu_sel;
    logic [2:0]  ex_br_type;
    logic        ex_branch, ex_jal, ex_jalr;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]  ex_wb_sel;
    logic        stop;

    int n_vec  = 0;
    int n_miss = 0;

    id_stage_pipelined dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_ready(id_ready), .flush(flush), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_alu_sel(ex_alu_sel),
        .ex_br_type(ex_br_type), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_wb_sel(ex_wb_sel), .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] d0, input logic [31:0] d1);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        rf_rd0   = d0;
        rf_rd1   = d1;
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0;
        rf_rd0 = '0; rf_rd1 = '0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        tick(); tick();
        check_vec("rst_valid", 32'(ex_valid), 32'd0);
        check_vec("rst_stop", 32'(stop), 32'd0);
        check_vec("rst_imm", ex_imm, 32'd0);
        rst = 1'b1;
        #1;
        check_vec("rst_ready", 32'(id_ready), 32'd1);

        // addi x5,x0,-1
        present(32'h100, 32'hFFF00293, 32'hDEAD, 32'hBEEF);
        #1;
        check_vec("addi_ra0", 32'(rf_ra0), 32'd0);
        check_vec("addi_ra1", 32'(rf_ra1), 32'd31);
        tick();
        check_vec("addi_valid", 32'(ex_valid), 32'd1);
        check_vec("addi_imm", ex_imm, 32'hFFFFFFFF);
        check_vec("addi_src2", ex_src2, 32'hFFFFFFFF);
        check_vec("addi_src1", ex_src1, 32'h0);
        check_vec("addi_rd", 32'(ex_rd), 32'd5);
        check_vec("addi_rw", 32'(ex_reg_write), 32'd1);
        check_vec("addi_pc", ex_pc, 32'h100);

        // asynchronous reset in mid-cycle while ex_valid=1
        rst = 1'b0;
        #1;
        check_vec("arst_valid", 32'(ex_valid), 32'd0);
        check_vec("arst_rw", 32'(ex_reg_write), 32'd0);
        check_vec("arst_imm", ex_imm, 32'd0);
        check_vec("arst_stop", 32'(stop), 32'd0);
        rst = 1'b1;
        if_valid = 1'b0;
        tick();

        // lw x6,0(x1) then add x7,x6,x2 -> one stall cycle
        present(32'h104, 32'h0000A303, 32'h100, 32'h0);
        tick();
        check_vec("lw_mrd", 32'(ex_mem_read), 32'd1);
        check_vec("lw_wbsel", 32'(ex_wb_sel), 32'd1);
        check_vec("lw_src1", ex_src1, 32'h100);
        present(32'h108, 32'h002303B3, 32'h11, 32'h22);
        #1;
        check_vec("lu_ready", 32'(id_ready), 32'd0);
        tick();
        check_vec("lu_bubble", 32'(ex_valid), 32'd0);
        check_vec("lu_bub_rw", 32'(ex_reg_write), 32'd0);
        check_vec("lu_ready2", 32'(id_ready), 32'd1);
        tick();
        check_vec("add_valid", 32'(ex_valid), 32'd1);
        check_vec("add_rd", 32'(ex_rd), 32'd7);
        check_vec("add_src1", ex_src1, 32'h11);
        check_vec("add_src2", ex_src2, 32'h22);
        check_vec("add_pc", ex_pc, 32'h108);

        // sub x8,x1,x2
        present(32'h10C, 32'h40208433, 32'd10, 32'd3);
        tick();
        check_vec("sub_alu", 32'(ex_alu_sel), 32'd1);
        check_vec("sub_rs2d", ex_rs2_data, 32'd3);

        // WB->ID bypass: add x4,x3,x0 with WB writing x3
        present(32'h110, 32'h00018233, 32'h0, 32'h55);
        wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h1234;
        tick();
        check_vec("byp_src1", ex_src1, 32'h1234);
        check_vec("byp_src2_x0", ex_src2, 32'h0);
        wb_we = 1'b0;

        // sw x2,8(x1)
        present(32'h114, 32'h0020A423, 32'h1000, 32'hCAFE);
        tick();
        check_vec("sw_mwr", 32'(ex_mem_write), 32'd1);
        check_vec("sw_rw", 32'(ex_reg_write), 32'd0);
        check_vec("sw_imm", ex_imm, 32'd8);
        check_vec("sw_rs2d", ex_rs2_data, 32'hCAFE);

        // beq x1,x2,-4
        present(32'h200, 32'hFE208EE3, 32'h5, 32'h6);
        tick();
        check_vec("beq_br", 32'(ex_branch), 32'd1);
        check_vec("beq_type", 32'(ex_br_type), 32'd0);
        check_vec("beq_imm", ex_imm, 32'hFFFFFFFC);
        check_vec("beq_src2", ex_src2, 32'h6);

        // lui x9,0x12345
        present(32'h204, 32'h123454B7, 32'h777, 32'h0);
        tick();
        check_vec("lui_src1", ex_src1, 32'h0);
        check_vec("lui_src2", ex_src2, 32'h12345000);
        check_vec("lui_rd", 32'(ex_rd), 32'd9);

        // jal x1,16
        present(32'h300, 32'h010000EF, 32'h0, 32'h0);
        tick();
        check_vec("jal_jal", 32'(ex_jal), 32'd1);
        check_vec("jal_wbsel", 32'(ex_wb_sel), 32'd2);
        check_vec("jal_src1", ex_src1, 32'h300);
        check_vec("jal_imm", ex_imm, 32'd16);

        // srai x10,x1,3
        present(32'h304, 32'h4030D513, 32'h80000000, 32'h0);
        tick();
        check_vec("srai_alu", 32'(ex_alu_sel), 32'd9);
        check_vec("srai_imm", ex_imm, 32'h403);

        // flush coincident with a load-use stall
        present(32'h308, 32'h0000A303, 32'h0, 32'h0);
        tick();
        check_vec("fl_lw", 32'(ex_mem_read), 32'd1);
        present(32'h30C, 32'h002303B3, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check_vec("fl_ready", 32'(id_ready), 32'd1);
        tick();
        check_vec("fl_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0;
        if_valid = 1'b0;
        tick();
        check_vec("fl_noretry", 32'(ex_valid), 32'd0);

        // all-zero instruction: bubble without stop
        present(32'h400, 32'h0, 32'h0, 32'h0);
        tick();
        check_vec("zero_valid", 32'(ex_valid), 32'd0);
        check_vec("zero_stop", 32'(stop), 32'd0);

        // illegal opcode -> sticky stop
        present(32'h404, 32'h0000007F, 32'h0, 32'h0);
        tick();
        check_vec("ill_stop", 32'(stop), 32'd1);
        check_vec("ill_valid", 32'(ex_valid), 32'd0);
        present(32'h408, 32'h002303B3, 32'h1, 32'h2);
        #1;
        check_vec("stp_ready", 32'(id_ready), 32'd0);
        tick();
        check_vec("stp_valid", 32'(ex_valid), 32'd0);
        tick();
        check_vec("stp_hold", 32'(stop), 32'd1);
        rst = 1'b0;
        #1;
        check_vec("stp_rst", 32'(stop), 32'd0);
        rst = 1'b1;
        #1;
        check_vec("post_ready", 32'(id_ready), 32'd1);
        tick();
        check_vec("post_valid", 32'(ex_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
